// File: rtl/jtag_tap_controller.sv
// jtag_tap_controller: IEEE 1149.1 TAP controller with the 16-state TAP FSM,
// an IR_WIDTH-bit instruction register, BYPASS and IDCODE data registers and
// select/strobe decode for up to USER_CHANNELS external user data chains.
// Build option: define JTAG_TAP_IDCODE_EN to build the IDCODE register and to
// make IDCODE_OP the reset opcode. Without it, IDCODE_OP decodes to BYPASS and
// the reset opcode is all-ones.
module jtag_tap_controller #(
  parameter int          IR_WIDTH      = 4,
  parameter logic [31:0] IDCODE_VALUE  = 32'h1000_0001,
  parameter int          IDCODE_OP     = 1,
  parameter int          USER_CHANNELS = 2,
  parameter int          USER_OP_BASE  = 8
) (
  input  logic                     tck,
  input  logic                     trst,
  input  logic                     tms,
  input  logic                     tdi,
  output logic                     tdo,
  output logic                     tdo_en,
  output logic [IR_WIDTH-1:0]      ir_q,
  output logic                     state_tlr,
  output logic                     state_rti,
  output logic [USER_CHANNELS-1:0] user_sel,
  output logic                     dr_capture,
  output logic                     dr_shift,
  output logic                     dr_update,
  input  logic [USER_CHANNELS-1:0] user_tdo
);

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
  } tap_state_e;

  // Fixed pattern loaded in Capture-IR; the trailing 01 lets a host find IR length.
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);
`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] RESET_OP = IR_WIDTH'(IDCODE_OP);
`else
  localparam logic [IR_WIDTH-1:0] RESET_OP = '1;
`endif

  tap_state_e          state_q, state_d;
  logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
  logic [IR_WIDTH-1:0] ir_d;
  logic                bypass_q, bypass_d;
  logic                sel_idcode;
  logic                sel_bypass;
  logic                idcode_bit;
  logic                dr_bit;
  logic                tdo_d, tdo_en_d;

  // Next-state graph and the combinational state decodes.
  always_comb begin
    state_d    = state_q;
    state_tlr  = 1'b0;
    state_rti  = 1'b0;
    dr_capture = 1'b0;
    dr_shift   = 1'b0;
    dr_update  = 1'b0;
    case (state_q)
      TLR:      state_d = tms ? TLR      : RTI;
      RTI:      state_d = tms ? SEL_DR   : RTI;
      SEL_DR:   state_d = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   state_d = tms ? EX1_DR   : SH_DR;
      SH_DR:    state_d = tms ? EX1_DR   : SH_DR;
      EX1_DR:   state_d = tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: state_d = tms ? EX2_DR   : PAUSE_DR;
      EX2_DR:   state_d = tms ? UPD_DR   : SH_DR;
      UPD_DR:   state_d = tms ? SEL_DR   : RTI;
      SEL_IR:   state_d = tms ? TLR      : CAP_IR;
      CAP_IR:   state_d = tms ? EX1_IR   : SH_IR;
      SH_IR:    state_d = tms ? EX1_IR   : SH_IR;
      EX1_IR:   state_d = tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: state_d = tms ? EX2_IR   : PAUSE_IR;
      EX2_IR:   state_d = tms ? UPD_IR   : SH_IR;
      UPD_IR:   state_d = tms ? SEL_DR   : RTI;
      default:  state_d = TLR;
    endcase
    state_tlr  = (state_q == TLR);
    state_rti  = (state_q == RTI);
    dr_capture = (state_q == CAP_DR);
    dr_shift   = (state_q == SH_DR);
    dr_update  = (state_q == UPD_DR);
  end

  // TAP state register.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) state_q <= TLR;
    else      state_q <= state_d;
  end

  // Instruction decode; IDCODE takes priority over an overlapping user opcode
  // and the all-ones opcode is always BYPASS.
  always_comb begin
`ifdef JTAG_TAP_IDCODE_EN
    sel_idcode = (ir_q == IR_WIDTH'(IDCODE_OP));
`else
    sel_idcode = 1'b0;
`endif
    user_sel = '0;
    for (int k = 0; k < USER_CHANNELS; k++) begin
      user_sel[k] = !sel_idcode && (ir_q != '1) &&
                    (ir_q == IR_WIDTH'(USER_OP_BASE + k));
    end
    sel_bypass = !sel_idcode && !(|user_sel);
  end

  // IR shift/capture, IR update on leaving Update-IR, BYPASS capture/shift.
  always_comb begin
    ir_sr_d  = ir_sr_q;
    ir_d     = ir_q;
    bypass_d = bypass_q;
    case (state_q)
      CAP_IR: ir_sr_d = IR_CAPTURE;
      SH_IR:  ir_sr_d = {tdi, ir_sr_q[IR_WIDTH-1:1]};
      UPD_IR: ir_d    = ir_sr_q;
      CAP_DR: if (sel_bypass) bypass_d = 1'b0;
      SH_DR:  if (sel_bypass) bypass_d = tdi;
      default: ;
    endcase
    // Entering Test-Logic-Reset restores the reset opcode on the same edge.
    if (state_d == TLR) ir_d = RESET_OP;
  end

  // IR shift register, current instruction and BYPASS bit.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      ir_sr_q  <= IR_CAPTURE;
      ir_q     <= RESET_OP;
      bypass_q <= 1'b0;
    end else begin
      ir_sr_q  <= ir_sr_d;
      ir_q     <= ir_d;
      bypass_q <= bypass_d;
    end
  end

`ifdef JTAG_TAP_IDCODE_EN
  logic [31:0] idcode_sr_q, idcode_sr_d;

  // IDCODE capture and right shift with tdi entering bit 31.
  always_comb begin
    idcode_sr_d = idcode_sr_q;
    if (sel_idcode && state_q == CAP_DR) idcode_sr_d = IDCODE_VALUE;
    if (sel_idcode && state_q == SH_DR)  idcode_sr_d = {tdi, idcode_sr_q[31:1]};
    idcode_bit = idcode_sr_q[0];
  end

  // IDCODE shift register.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) idcode_sr_q <= IDCODE_VALUE;
    else      idcode_sr_q <= idcode_sr_d;
  end
`else
  assign idcode_bit = 1'b0;
`endif

  // TDO source select: IR bit 0 in Shift-IR, selected DR serial out in Shift-DR.
  always_comb begin
    tdo_d    = 1'b0;
    tdo_en_d = 1'b0;
    if (sel_idcode)     dr_bit = idcode_bit;
    else if (|user_sel) dr_bit = |(user_sel & user_tdo);
    else                dr_bit = bypass_q;
    if (state_q == SH_IR) begin
      tdo_d    = ir_sr_q[0];
      tdo_en_d = 1'b1;
    end else if (state_q == SH_DR) begin
      tdo_d    = dr_bit;
      tdo_en_d = 1'b1;
    end
  end

  // TDO and its enable are launched on the falling edge of tck.
  always_ff @(negedge tck or posedge trst) begin
    if (trst) begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
    end else begin
      tdo    <= tdo_d;
      tdo_en <= tdo_en_d;
    end
  end

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Bench for jtag_tap_controller: directed scans from the test plan followed by
// randomized TMS/TDI/user_tdo traffic, all checked against a queue-based model.
module tb_jtag_tap_controller;

  localparam int          W    = 4;
  localparam logic [31:0] IDV  = 32'h1000_0001;
  localparam int          IDOP = 1;
  localparam int          CH   = 2;
  localparam int          BASE = 8;
`ifdef JTAG_TAP_IDCODE_EN
  localparam bit ID_EN = 1'b1;
`else
  localparam bit ID_EN = 1'b0;
`endif
  localparam logic [W-1:0] RESET_OP = ID_EN ? W'(IDOP) : {W{1'b1}};

  // Model state numbering: DR branch 2..8, IR branch is the same shape at +7.
  localparam int S_TLR = 0, S_RTI = 1, S_SDR = 2, S_CDR = 3, S_SHDR = 4,
                 S_E1DR = 5, S_PDR = 6, S_E2DR = 7, S_UDR = 8, S_SIR = 9,
                 S_CIR = 10, S_SHIR = 11, S_UIR = 15;

  // clock / reset block
  logic tck = 1'b0;
  logic trst, tms, tdi;
  logic [CH-1:0] user_tdo;
  logic tdo, tdo_en, state_tlr, state_rti, dr_capture, dr_shift, dr_update;
  logic [W-1:0] ir_q;
  logic [CH-1:0] user_sel;

  always #5 tck = ~tck;

  jtag_tap_controller #(
    .IR_WIDTH(W), .IDCODE_VALUE(IDV), .IDCODE_OP(IDOP),
    .USER_CHANNELS(CH), .USER_OP_BASE(BASE)
  ) dut (
    .tck(tck), .trst(trst), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
    .ir_q(ir_q), .state_tlr(state_tlr), .state_rti(state_rti),
    .user_sel(user_sel), .dr_capture(dr_capture), .dr_shift(dr_shift),
    .dr_update(dr_update), .user_tdo(user_tdo)
  );

  // behavioural model
  int           m_state;
  bit           irq[$];
  bit           drq[$];
  logic [W-1:0] m_ir;
  int           checks = 0;
  int           errors = 0;
  logic         last_tdo, last_tdo_en;
  int           upd_count;

  function automatic int nxt(int s, bit t);
    int off, r;
    if (s == S_TLR) return t ? S_TLR : S_RTI;
    if (s == S_RTI) return t ? S_SDR : S_RTI;
    if (s == S_SDR) return t ? S_SIR : S_CDR;
    if (s == S_SIR) return t ? S_TLR : S_CIR;
    off = (s >= S_SIR) ? 7 : 0;
    r = s - off;
    if (r == S_UDR) return t ? S_SDR : S_RTI;
    if (r == S_CDR || r == S_SHDR) r = t ? S_E1DR : S_SHDR;
    else if (r == S_E1DR)          r = t ? S_UDR  : S_PDR;
    else if (r == S_PDR)           r = t ? S_E2DR : S_PDR;
    else                           r = t ? S_UDR  : S_SHDR;
    return r + off;
  endfunction

  // 0 = BYPASS, 1 = IDCODE, 2+k = user chain k
  function automatic int sel_of(logic [W-1:0] op);
    if (ID_EN && op == W'(IDOP)) return 1;
    if (op != {W{1'b1}} && int'(op) >= BASE && int'(op) < BASE + CH)
      return 2 + int'(op) - BASE;
    return 0;
  endfunction

  task automatic ir_capture_model();
    irq.delete();
    irq.push_back(1'b1);
    for (int i = 1; i < W; i++) irq.push_back(1'b0);
  endtask

  task automatic model_reset();
    m_state = S_TLR;
    ir_capture_model();
    m_ir = RESET_OP;
    drq.delete();
  endtask

  task automatic model_edge(input bit t, input bit d);
    int sel;
    logic [31:0] idv;
    logic [W-1:0] v;
    sel = sel_of(m_ir);
    idv = IDV;
    if (m_state == S_CIR) ir_capture_model();
    else if (m_state == S_SHIR) begin
      void'(irq.pop_front());
      irq.push_back(d);
    end else if (m_state == S_CDR) begin
      drq.delete();
      if (sel == 1) for (int i = 0; i < 32; i++) drq.push_back(idv[i]);
      else if (sel == 0) drq.push_back(1'b0);
    end else if (m_state == S_SHDR) begin
      if (sel < 2 && drq.size() > 0) begin
        void'(drq.pop_front());
        drq.push_back(d);
      end
    end else if (m_state == S_UIR) begin
      for (int i = 0; i < W; i++) v[i] = irq[i];
      m_ir = v;
    end
    m_state = nxt(m_state, t);
    if (m_state == S_TLR) m_ir = RESET_OP;
  endtask

  // scoreboard compare
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: one TCK cycle, state outputs checked after the rising edge and
  // tdo/tdo_en checked after the falling edge
  task automatic tick(input bit t, input bit d);
    int   sel;
    logic e;
    logic [63:0] exp_sel;
    tms = t;
    tdi = d;
    user_tdo = CH'($urandom);
    @(posedge tck);
    model_edge(t, d);
    #1;
    sel = sel_of(m_ir);
    exp_sel = (sel >= 2) ? (64'd1 << (sel - 2)) : 64'd0;
    chk("state_tlr", state_tlr, m_state == S_TLR);
    chk("state_rti", state_rti, m_state == S_RTI);
    chk("dr_capture", dr_capture, m_state == S_CDR);
    chk("dr_shift", dr_shift, m_state == S_SHDR);
    chk("dr_update", dr_update, m_state == S_UDR);
    chk("ir_q", ir_q, m_ir);
    chk("user_sel", user_sel, exp_sel);
    if (dr_update === 1'b1) upd_count++;
    @(negedge tck);
    if (m_state == S_SHIR)      e = irq[0];
    else if (m_state == S_SHDR) e = (sel >= 2) ? user_tdo[sel-2] :
                                    (drq.size() > 0 ? drq[0] : 1'bx);
    else                        e = 1'b0;
    #1;
    chk("tdo_en", tdo_en, m_state == S_SHIR || m_state == S_SHDR);
    chk("tdo", tdo, e);
    last_tdo = tdo;
    last_tdo_en = tdo_en;
  endtask

  task automatic to_rti();
    repeat (5) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  // From RTI: capture/shift an opcode into IR and update it, ending in RTI.
  task automatic load_ir(input logic [W-1:0] op, output logic [W-1:0] cap);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    cap[0] = last_tdo;
    for (int i = 0; i < W; i++) begin
      tick(i == W - 1, op[i]);
      if (i < W - 1) cap[i+1] = last_tdo;
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  // From RTI: scan n bits through the selected DR, ending in RTI.
  task automatic scan_dr(input int n, input logic [63:0] data,
                         output logic [63:0] col, output int en_cnt);
    col = '0;
    upd_count = 0;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    col[0] = last_tdo;
    en_cnt = int'(last_tdo_en);
    for (int i = 0; i < n; i++) begin
      tick(i == n - 1, data[i]);
      if (i < n - 1) col[i+1] = last_tdo;
      en_cnt += int'(last_tdo_en);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  // stimulus
  initial begin
    logic [63:0]  col;
    logic [W-1:0] cap;
    logic [W-1:0] op;
    int           en;
    int           n;

    trst = 1'b1;
    tms = 1'b1;
    tdi = 1'b0;
    user_tdo = '0;
    model_reset();
    #12;
    chk("rst_tlr", state_tlr, 1'b1);
    chk("rst_rti", state_rti, 1'b0);
    chk("rst_tdo", tdo, 1'b0);
    chk("rst_tdo_en", tdo_en, 1'b0);
    chk("rst_ir_q", ir_q, RESET_OP);
    chk("rst_user_sel", user_sel, 2'b00);
    chk("rst_strobes", {dr_capture, dr_shift, dr_update}, 3'b000);
    @(negedge tck);
    #1 trst = 1'b0;
    tick(1'b0, 1'b0);

    // IDCODE read straight after reset (BYPASS zeros when IDCODE is not built)
    scan_dr(32, 64'd0, col, en);
    chk("idcode_read", col[31:0], ID_EN ? IDV : 32'h0);
    chk("idcode_en_edges", en, 32);
    chk("dr_update_once", upd_count, 1);

    // IR capture pattern, then load BYPASS
    load_ir(4'hF, cap);
    chk("ir_capture", cap, 4'b0001);
    chk("ir_q_after_upd", ir_q, 4'hF);

    // BYPASS: tdi 1,0,1,1 -> tdo 0,1,0,1
    scan_dr(4, 64'hD, col, en);
    chk("bypass_seq", col[3:0], 4'hA);

    // user chain 1
    load_ir(4'd9, cap);
    chk("user_sel_9", user_sel, 2'b10);
    scan_dr(12, {$urandom, $urandom}, col, en);
    chk("user_update_once", upd_count, 1);

    // TLR recovery from Pause-IR
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    repeat (5) tick(1'b1, 1'b0);
    chk("tlr_recovery", state_tlr, 1'b1);
    chk("tlr_ir_q", ir_q, RESET_OP);

    // async reset during the 10th bit of an IDCODE shift
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    repeat (9) tick(1'b0, 1'b1);
    #2 trst = 1'b1;
    model_reset();
    #1;
    chk("async_tlr", state_tlr, 1'b1);
    chk("async_tdo_en", tdo_en, 1'b0);
    chk("async_tdo", tdo, 1'b0);
    chk("async_ir_q", ir_q, RESET_OP);
    @(posedge tck);
    #1 chk("async_hold_tlr", state_tlr, 1'b1);
    @(negedge tck);
    #1 trst = 1'b0;
    tick(1'b0, 1'b0);
    scan_dr(32, 64'd0, col, en);
    chk("idcode_reread", col[31:0], ID_EN ? IDV : 32'h0);

    // randomized traffic
    repeat (50) begin
      to_rti();
      case ($urandom_range(0, 4))
        0:       op = W'(IDOP);
        1:       op = W'(BASE);
        2:       op = W'(BASE + 1);
        3:       op = {W{1'b1}};
        default: op = W'($urandom_range(0, 15));
      endcase
      load_ir(op, cap);
      chk("rand_ir_capture", cap, 4'b0001);
      n = $urandom_range(1, 40);
      scan_dr(n, {$urandom, $urandom}, col, en);
      chk("rand_en_edges", en, n);
      repeat (20) tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_tap_controller.md
# jtag_tap_controller

Full IEEE 1149.1 TAP controller: 16-state TAP FSM, parametrised instruction register, BYPASS and IDCODE data registers, and decode for up to USER_CHANNELS external user data chains. It sits directly behind the chip's JTAG pins. It owns TDO and its output enable, and drives per-chain select and capture/shift/update strobes into debug blocks.

## Interface
- IR_WIDTH, 4: instruction register width, minimum 2.
- IDCODE_VALUE, 32'h1000_0001: IDCODE register contents; bit 0 must be 1.
- IDCODE_OP, 1: IDCODE opcode.
- USER_CHANNELS, 2: number of user DR chains, 1..8.
- USER_OP_BASE, 8: opcode of user chain 0; chain k uses USER_OP_BASE+k.

- tck  in  1  JTAG clock; all logic runs on it (rising edge, except TDO output on falling edge).
- trst  in  1  asynchronous, active-high reset.
- tms  in  1  test mode select, sampled on the rising edge of tck.
- tdi  in  1  test data in, sampled on the rising edge of tck.
- tdo  out  1  test data out, changes on the falling edge of tck.
- tdo_en  out  1  high while shifting; drives the pad tristate.
- ir_q  out  IR_WIDTH  current (updated) instruction.
- state_tlr  out  1  FSM is in Test-Logic-Reset.
- state_rti  out  1  FSM is in Run-Test/Idle.
- user_sel  out  USER_CHANNELS  one-hot; ir_q selects chain k.
- dr_capture  out  1  FSM is in Capture-DR.
- dr_shift  out  1  FSM is in Shift-DR.
- dr_update  out  1  FSM is in Update-DR.
- user_tdo  in  USER_CHANNELS  serial out of each user chain.

## Operation
- FSM states and transitions are the standard 1149.1 graph.
  - TLR: tms=1 stays in TLR; tms=0 goes to RTI.
  - RTI: tms=1 goes to SelDR.
  - SelDR: tms=1 goes to SelIR; tms=0 goes to CapDR.
  - CapDR/ShDR: tms=1 goes to Ex1DR; tms=0 goes to ShDR.
  - Ex1DR: tms=1 goes to UpdDR; tms=0 goes to PauseDR.
  - PauseDR: tms=1 goes to Ex2DR.
  - Ex2DR: tms=1 goes to UpdDR; tms=0 goes to ShDR.
  - UpdDR: tms=1 goes to SelDR; tms=0 goes to RTI.
  - SelIR: tms=1 goes to TLR; tms=0 goes to CapIR.
  - The IR branch mirrors the DR branch.
- IR shift register (IR_WIDTH bits):
  - CapIR loads {0..., 2'b01}.
  - ShIR shifts right; tdi enters the MSB; bit 0 feeds tdo.
- ir_q:
  - Loaded from the IR shift register on the rising edge that exits UpdIR.
  - Forced to the reset opcode while in TLR.
  - The reset opcode is IDCODE_OP (see Configuration).
- DR selection by ir_q:
  - IDCODE_OP selects the 32-bit IDCODE register.
  - USER_OP_BASE+k, for k<USER_CHANNELS, selects user chain k and drives user_sel[k]=1.
  - All-ones and every other opcode select BYPASS.
- BYPASS: 1-bit register. CapDR loads 0; ShDR loads tdi.
- IDCODE: CapDR loads IDCODE_VALUE; ShDR shifts right with tdi into bit 31; bit 0 feeds tdo.
- User chains:
  - dr_capture, dr_shift and dr_update are unqualified state decodes.
  - Each user block ANDs them with its own user_sel bit.
  - During ShDR, tdo takes user_tdo[k].
- TDO mux: ShIR selects IR bit 0; ShDR selects the selected DR's serial out.
- If the opcode decodes to both IDCODE and a user channel (parameter overlap), IDCODE wins.
- Five consecutive rising edges with tms=1 reach TLR from any state.

## Timing
- FSM state, IR shift register, BYPASS and IDCODE shift registers update on the rising edge of tck.
- tdo and tdo_en are registered on the falling edge of tck.
  - In ShIR/ShDR, tdo_en=1 and tdo = the mux output.
  - Otherwise tdo_en=0 and tdo=0.
  - The first shifted bit therefore appears half a cycle after the edge that enters the Shift state.
- Reset while trst=1, asynchronous, including mid-shift:
  - state = TLR.
  - ir_q = reset opcode.
  - IR shift register = {0..., 2'b01}.
  - BYPASS = 0; IDCODE shift register = IDCODE_VALUE.
  - tdo = 0, tdo_en = 0; all strobes are 0 except state_tlr=1.
  - user_sel = 0.
- State-decode outputs are combinational from the state register, so they are valid the whole cycle the FSM occupies that state.
- A Pause state holds every shift register unchanged.

## Configuration
- JTAG_TAP_IDCODE_EN defined:
  - IDCODE register present.
  - Reset/TLR opcode = IDCODE_OP.
- JTAG_TAP_IDCODE_EN undefined:
  - No IDCODE register is built.
  - IDCODE_OP decodes to BYPASS.
  - Reset/TLR opcode = all-ones (BYPASS).
  - CapDR immediately after reset therefore shifts out a leading 0.

## Test plan
- Reset and IDCODE read: assert trst, release, tms 0,1,0,0 to reach ShDR, shift 32 bits with tdi=0 -> tdo sequence LSB-first equals 32'h1000_0001, tdo_en=1 for exactly 32 falling edges.
- IR capture: go to ShIR, shift 4 bits -> tdo reads 1,0,0,0. Shift in 4'hF, then UpdIR -> ir_q=4'hF.
- BYPASS: ir_q=4'hF, ShDR, drive tdi 1,0,1,1 -> tdo 0,1,0,1 (capture 0, one-cycle delay).
- User chain: load opcode 9 -> user_sel=2'b10. In ShDR with user_tdo[1] toggling -> tdo follows user_tdo[1]. dr_update is high for one cycle in UpdDR.
- TLR recovery: from PauseIR, apply 5 rising edges with tms=1 -> state_tlr=1 and ir_q=IDCODE_OP (all-ones with the macro undefined).
- Async reset mid-shift: assert trst at the 10th bit of an IDCODE shift -> immediate state_tlr=1, tdo_en=0, tdo=0. Re-reading IDCODE returns the full value.
